smc_rank_sum: RTL and testbench

- Consumer end of the SMC calculator path.
- Captures the six per-transistor Id or gm results produced by the calculator.
- Sorts them over several clock cycles, selects the three largest or three smallest, and emits one weighted sum through a valid/ready handshake.
- Sits between the calculator outputs and the SMC top-level output register.

---
 rtl/smc_pkg.sv | 11 +
 rtl/smc_cas.sv | 14 +
 rtl/smc_rank_sum.sv | 93 +++++++++
 tb/tb_smc_rank_sum.sv | 136 +++++++++++++
 4 files changed

// File: rtl/smc_pkg.sv
// smc_pkg: shared states, sizes, weights and mode bit positions for the SMC rank-sum path
package smc_pkg;
  typedef enum logic [1:0] {IDLE, SORT, SUM, DONE} state_t;
  localparam int SMC_N = 6;
  localparam int ID_W0 = 3;
  localparam int ID_W1 = 4;
  localparam int ID_W2 = 5;
  localparam int SORT_PASSES = 6;
  localparam int MODE_ID = 0;
  localparam int MODE_MAX = 1;
endpackage

// File: rtl/smc_cas.sv
// smc_cas: combinational compare-and-swap, lo gets the smaller operand
module smc_cas #(
  parameter int DW = 10
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] hi
);
  logic swap;
  assign swap = a > b;
  assign lo = swap ? b : a;
  assign hi = swap ? a : b;
endmodule

// File: rtl/smc_rank_sum.sv
// smc_rank_sum: sorts six Id/gm values over six cycles and emits a weighted sum of the top or bottom three
module smc_rank_sum
  import smc_pkg::*;
#(
  parameter int DW = 10,
  parameter int OW = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [6*DW-1:0]   id_in,
  input  logic [6*DW-1:0]   gm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     out_data
);
  state_t state, state_nx;
  logic [DW-1:0] v [SMC_N];
  logic [DW-1:0] v_nx [SMC_N];
  logic [DW-1:0] ca [3];
  logic [DW-1:0] cb [3];
  logic [DW-1:0] lo [3];
  logic [DW-1:0] hi [3];
  logic [1:0] mode_q;
  logic [2:0] pass;
  logic odd;
  logic [DW-1:0] n0, n1, n2;
  logic [OW-1:0] sum;
  assign odd = pass[0];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    ca[0] = v[0];
    cb[0] = v[1];
    ca[1] = odd ? v[1] : v[2];
    cb[1] = odd ? v[2] : v[3];
    ca[2] = odd ? v[3] : v[4];
    cb[2] = odd ? v[4] : v[5];
  end
  genvar i;
  for (i = 0; i < 3; i++) begin : g_cas
    smc_cas #(.DW(DW)) u_cas (.a(ca[i]), .b(cb[i]), .lo(lo[i]), .hi(hi[i]));
  end
  always_comb begin
    v_nx[0] = odd ? v[0]  : lo[0];
    v_nx[1] = odd ? lo[1] : hi[0];
    v_nx[2] = odd ? hi[1] : lo[1];
    v_nx[3] = odd ? lo[2] : hi[1];
    v_nx[4] = odd ? hi[2] : lo[2];
    v_nx[5] = odd ? v[5]  : hi[2];
  end
  always_comb begin
    n0 = mode_q[MODE_MAX] ? v[5] : v[0];
    n1 = mode_q[MODE_MAX] ? v[4] : v[1];
    n2 = mode_q[MODE_MAX] ? v[3] : v[2];
    sum = mode_q[MODE_ID]
        ? OW'(ID_W0) * OW'(n0) + OW'(ID_W1) * OW'(n1) + OW'(ID_W2) * OW'(n2)
        : OW'(n0) + OW'(n1) + OW'(n2);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? SORT : IDLE;
      SORT: state_nx = pass == 3'(SORT_PASSES - 1) ? SUM : SORT;
      SUM:  state_nx = DONE;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pass <= '0;
      mode_q <= '0;
      out_data <= '0;
      for (int k = 0; k < SMC_N; k++) v[k] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        mode_q <= mode;
        pass <= '0;
        for (int k = 0; k < SMC_N; k++) v[k] <= mode[MODE_ID] ? id_in[k*DW +: DW] : gm_in[k*DW +: DW];
      end
      if (state == SORT) begin
        pass <= pass + 3'd1;
        for (int k = 0; k < SMC_N; k++) v[k] <= v_nx[k];
      end
      if (state == SUM) out_data <= sum;
    end
  end
endmodule

// File: tb/tb_smc_rank_sum.sv
// tb_smc_rank_sum: randomized and directed check of smc_rank_sum against a sort-and-select model
module tb_smc_rank_sum;
  localparam int DW = 10;
  localparam int OW = 14;
  logic clk = 0;
  logic reset = 1;
  logic in_valid = 0;
  logic in_ready;
  logic [1:0] mode = '0;
  logic [6*DW-1:0] id_in = '0;
  logic [6*DW-1:0] gm_in = '0;
  logic out_valid;
  logic out_ready = 1;
  logic [OW-1:0] out_data;
  int n_tests = 0;
  int n_fail = 0;
  smc_rank_sum #(.DW(DW), .OW(OW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .id_in(id_in), .gm_in(gm_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [6*DW-1:0] pack6(input int a0, a1, a2, a3, a4, a5);
    return {DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction
  function automatic int model(input logic [1:0] m, input logic [6*DW-1:0] id, input logic [6*DW-1:0] gm);
    int a [6];
    int t, x, y, z;
    logic [6*DW-1:0] src;
    src = m[0] ? id : gm;
    for (int k = 0; k < 6; k++) a[k] = int'(src[k*DW +: DW]);
    for (int p = 0; p < 6; p++)
      for (int k = 0; k < 5; k++)
        if (a[k] > a[k+1]) begin
          t = a[k]; a[k] = a[k+1]; a[k+1] = t;
        end
    x = m[1] ? a[5] : a[0];
    y = m[1] ? a[4] : a[1];
    z = m[1] ? a[3] : a[2];
    return m[0] ? 3*x + 4*y + 5*z : x + y + z;
  endfunction
  function automatic logic [6*DW-1:0] rnd_vals(input int maxv);
    logic [6*DW-1:0] r;
    for (int k = 0; k < 6; k++) r[k*DW +: DW] = DW'($urandom_range(maxv, 0));
    return r;
  endfunction
  task automatic run(input string tag, input logic [1:0] m, input logic [6*DW-1:0] id,
                     input logic [6*DW-1:0] gm, input int stall);
    int exp;
    int lat;
    logic [OW-1:0] held;
    exp = model(m, id, gm);
    chk({tag, "_rdy_pre"}, 32'(in_ready), 1);
    mode = m; id_in = id; gm_in = gm; in_valid = 1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 0;
    mode = 2'($urandom);
    id_in = rnd_vals(1023);
    gm_in = rnd_vals(1023);
    chk({tag, "_rdy_busy"}, 32'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 7);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    held = out_data;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1;
      id_in = rnd_vals(1023);
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 1);
      chk({tag, "_hold_data"}, 32'(out_data), 32'(held));
      chk({tag, "_hold_rdy"}, 32'(in_ready), 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk({tag, "_rel_valid"}, 32'(out_valid), 0);
    chk({tag, "_rel_rdy"}, 32'(in_ready), 1);
    chk({tag, "_rel_data"}, 32'(out_data), 32'(held));
  endtask
  initial begin
    logic [6*DW-1:0] base;
    base = pack6(100, 5, 300, 42, 7, 250);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    for (int c = 0; c < 20; c++) begin
      chk("idle_rdy", 32'(in_ready), 1);
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_data", 32'(out_data), 0);
      @(posedge clk); #1;
    end
    run("id_max", 2'b11, base, '0, 0);
    chk("id_max_const", 32'(out_data), 2400);
    run("id_min", 2'b01, base, '0, 0);
    chk("id_min_const", 32'(out_data), 253);
    run("gm_max", 2'b10, rnd_vals(1023), pack6(10, 20, 30, 40, 50, 60), 0);
    chk("gm_max_const", 32'(out_data), 150);
    run("id_full", 2'b11, pack6(1023, 1023, 1023, 1023, 1023, 1023), '0, 0);
    chk("id_full_const", 32'(out_data), 12276);
    run("gm_tie", 2'b00, rnd_vals(1023), pack6(4, 4, 4, 4, 4, 4), 0);
    chk("gm_tie_const", 32'(out_data), 12);
    run("bp", 2'b11, base, '0, 5);
    mode = 2'b11; id_in = pack6(9, 8, 7, 6, 5, 4); in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_rdy", 32'(in_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    run("post_rst", 2'b11, base, '0, 0);
    chk("post_rst_const", 32'(out_data), 2400);
    for (int r = 0; r < 40; r++)
      run("rnd", 2'($urandom), rnd_vals(r % 3 == 0 ? 3 : 1023), rnd_vals(r % 4 == 0 ? 2 : 1023),
          int'($urandom_range(3, 0)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
